// File: rtl/san_axil_wr_master_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) between a write master and a slave.
// Ports: awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready.
interface san_axil_wr_master_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awaddr, awprot, awvalid,
        output wdata, wstrb, wvalid,
        output bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        input  wdata, wstrb, wvalid,
        input  bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/san_axil_wr_master.sv
// AXI4-Lite write initiator: one local command -> one AW/W/B transaction -> one rsp pulse.
// Ports: M_AXI_ACLK/M_AXI_ARESETN, cmd_* request, rsp_* completion, m_axi write channels.
module san_axil_wr_master #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                M_AXI_ACLK,
    input  logic                M_AXI_ARESETN,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_data,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    san_axil_wr_master_if.master m_axi
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_B
    } state_t;

    // Last counter value still inside the wait window.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t state_q;
    state_t state_d;

    logic [15:0] cnt_q;
    logic        awvalid_q;
    logic        wvalid_q;

    logic        do_accept;
    logic        aw_fin;
    logic        w_fin;
    logic        go_wait;
    logic        b_hit;
    logic        tmo_hit;

    // A channel is finished once its VALID is gone or handshakes now.
    assign aw_fin = !awvalid_q || m_axi.awready;
    assign w_fin  = !wvalid_q  || m_axi.wready;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        do_accept = 1'b0;
        go_wait   = 1'b0;
        b_hit     = 1'b0;
        tmo_hit   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    do_accept = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (aw_fin && w_fin) begin
                    go_wait = 1'b1;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                // BVALID takes priority over a coincident timeout.
                if (m_axi.bvalid) begin
                    b_hit   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            cnt_q        <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            m_axi.awaddr <= '0;
            m_axi.wdata  <= '0;
            m_axi.wstrb  <= '0;
            rsp_valid    <= 1'b0;
            rsp_resp     <= 2'b00;
            rsp_timeout  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (do_accept) begin
                m_axi.awaddr <= cmd_addr;
                m_axi.wdata  <= cmd_data;
                m_axi.wstrb  <= cmd_strb;
                awvalid_q    <= 1'b1;
                wvalid_q     <= 1'b1;
            end
            if (state_q == ISSUE) begin
                if (awvalid_q && m_axi.awready) begin
                    awvalid_q <= 1'b0;
                end
                if (wvalid_q && m_axi.wready) begin
                    wvalid_q <= 1'b0;
                end
            end
            if (go_wait) begin
                cnt_q <= '0;
            end else if (state_q == WAIT_B) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (b_hit) begin
                rsp_valid   <= 1'b1;
                rsp_resp    <= m_axi.bresp;
                rsp_timeout <= 1'b0;
            end else if (tmo_hit) begin
                rsp_valid   <= 1'b1;
                rsp_resp    <= 2'b11;
                rsp_timeout <= 1'b1;
            end
        end
    end

    // Gated by reset so both read 0 while the block is held in reset.
    assign cmd_ready     = M_AXI_ARESETN && (state_q == IDLE);
    assign m_axi.bready  = M_AXI_ARESETN && (state_q != ISSUE);
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.awprot  = 3'b000;

endmodule

// File: tb/tb_san_axil_wr_master.sv
// Directed bench for san_axil_wr_master: table of single transactions
// plus hand-written reset, stray-B and back-to-back sequences.
module tb_san_axil_wr_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    int checks;
    int errors;

    san_axil_wr_master_if #(.ADDR_W(3), .DATA_W(32)) bus ();

    san_axil_wr_master #(
        .ADDR_W (3),
        .DATA_W (32),
        .TIMEOUT(8)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESETN(rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .cmd_strb     (cmd_strb),
        .rsp_valid    (rsp_valid),
        .rsp_resp     (rsp_resp),
        .rsp_timeout  (rsp_timeout),
        .m_axi        (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_d;
        int          w_d;
        int          b_d;
        logic [1:0]  bresp;
        int          lat;
        logic [1:0]  exp_resp;
        logic        exp_to;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_txn(input int idx, input vec_t v);
        int   c;
        int   aw_hs;
        int   w_hs;
        int   aw_n;
        int   w_n;
        int   b_at;
        int   rsp_c;
        int   bad_pl;
        int   bad_br;
        int   bad_hs;
        bit   b_done;
        bit   aw_pend;
        bit   w_pend;
        logic [1:0] r_resp;
        logic r_to;
        c = 0; aw_hs = -1; w_hs = -1; aw_n = 0; w_n = 0;
        rsp_c = -1; bad_pl = 0; bad_br = 0; bad_hs = 0;
        b_done = 0; aw_pend = 0; w_pend = 0;
        r_resp = 2'b00; r_to = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr = v.addr;
        cmd_data = v.data;
        cmd_strb = v.strb;
        bus.awready = 1'b0;
        bus.wready = 1'b0;
        bus.bvalid = 1'b0;
        bus.bresp = v.bresp;
        @(negedge clk);
        chk($sformatf("v%0d_cmd_ready", idx), 64'(cmd_ready), 64'(1));
        while (rsp_c < 0 && c < 60) begin
            @(posedge clk); #1;
            c++;
            // Junk on the command port must be ignored outside IDLE.
            cmd_valid = 1'b0;
            cmd_addr = ~v.addr;
            cmd_data = ~v.data;
            cmd_strb = ~v.strb;
            bus.awready = (c >= 1 + v.aw_d);
            bus.wready = (c >= 1 + v.w_d);
            b_at = -1;
            if (aw_hs >= 0 && w_hs >= 0 && v.b_d >= 0)
                b_at = ((aw_hs > w_hs) ? aw_hs : w_hs) + 1 + v.b_d;
            bus.bvalid = (b_at >= 0) && (c >= b_at) && !b_done;
            @(negedge clk);
            if (bus.awvalid && bus.awaddr != v.addr) bad_pl++;
            if (bus.wvalid && (bus.wdata != v.data || bus.wstrb != v.strb))
                bad_pl++;
            if ((bus.awvalid || bus.wvalid) && bus.bready) bad_br++;
            if (aw_pend && !bus.awvalid) bad_hs++;
            if (w_pend && !bus.wvalid) bad_hs++;
            aw_pend = bus.awvalid && !bus.awready;
            w_pend = bus.wvalid && !bus.wready;
            if (bus.awvalid && bus.awready) begin aw_hs = c; aw_n++; end
            if (bus.wvalid && bus.wready) begin w_hs = c; w_n++; end
            if (bus.bvalid && bus.bready) b_done = 1;
            if (rsp_valid) begin
                rsp_c = c;
                r_resp = rsp_resp;
                r_to = rsp_timeout;
            end
        end
        @(posedge clk); #1;
        bus.bvalid = 1'b0;
        bus.awready = 1'b0;
        bus.wready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_rsp_pulse", idx), 64'(rsp_valid), 64'(0));
        chk($sformatf("v%0d_latency", idx), 64'(rsp_c), 64'(v.lat));
        chk($sformatf("v%0d_resp", idx), 64'(r_resp), 64'(v.exp_resp));
        chk($sformatf("v%0d_timeout", idx), 64'(r_to), 64'(v.exp_to));
        chk($sformatf("v%0d_aw_count", idx), 64'(aw_n), 64'(1));
        chk($sformatf("v%0d_w_count", idx), 64'(w_n), 64'(1));
        chk($sformatf("v%0d_payload", idx), 64'(bad_pl), 64'(0));
        chk($sformatf("v%0d_bready_issue", idx), 64'(bad_br), 64'(0));
        chk($sformatf("v%0d_valid_drop", idx), 64'(bad_hs), 64'(0));
        chk($sformatf("v%0d_awaddr", idx), 64'(bus.awaddr), 64'(v.addr));
    endtask

    task automatic back_to_back();
        logic [2:0]  a[4];
        logic [31:0] d[4];
        int  k_acc;
        int  k_aw;
        int  rsp_n;
        int  bad_ord;
        int  bad_rdy;
        bit  pend;
        a = '{3'd5, 3'd3, 3'd7, 3'd0};
        d = '{32'd11, 32'd22, 32'd33, 32'd44};
        k_acc = 0; k_aw = 0; rsp_n = 0;
        bad_ord = 0; bad_rdy = 0; pend = 0;
        @(posedge clk); #1;
        bus.awready = 1'b1;
        bus.wready = 1'b1;
        bus.bvalid = 1'b0;
        bus.bresp = 2'b00;
        cmd_valid = 1'b1;
        cmd_addr = a[0];
        cmd_data = d[0];
        cmd_strb = 4'hF;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cmd_ready && (k_acc > rsp_n) && !rsp_valid) bad_rdy++;
            if (rsp_valid) rsp_n++;
            if (bus.bvalid && bus.bready) pend = 0;
            if (bus.awvalid && bus.awready) begin
                if (k_aw > 3 || bus.awaddr != a[k_aw & 3] ||
                    bus.wdata != d[k_aw & 3]) bad_ord++;
                k_aw++;
                pend = 1;
            end
            if (cmd_valid && cmd_ready) k_acc++;
            @(posedge clk); #1;
            bus.bvalid = pend;
            if (k_acc >= 4) begin
                cmd_valid = 1'b0;
            end else begin
                cmd_addr = a[k_acc];
                cmd_data = d[k_acc];
            end
        end
        bus.awready = 1'b0;
        bus.wready = 1'b0;
        bus.bvalid = 1'b0;
        chk("b2b_accepts", 64'(k_acc), 64'(4));
        chk("b2b_aw_count", 64'(k_aw), 64'(4));
        chk("b2b_rsp_count", 64'(rsp_n), 64'(4));
        chk("b2b_order", 64'(bad_ord), 64'(0));
        chk("b2b_ready_low", 64'(bad_rdy), 64'(0));
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_data = '0;
        cmd_strb = '0;
        bus.awready = 1'b0;
        bus.wready = 1'b0;
        bus.bvalid = 1'b0;
        bus.bresp = 2'b00;

        //             addr  data           strb aw w  b  bresp lat resp  to
        tbl[0] = '{3'h4, 32'd100,       4'hF, 0, 0, 0, 2'b00, 3, 2'b00, 1'b0};
        tbl[1] = '{3'h1, 32'hA5A5_0001, 4'h3, 3, 0, 0, 2'b00, 6, 2'b00, 1'b0};
        tbl[2] = '{3'h6, 32'h1234_5678, 4'h8, 0, 2, 0, 2'b00, 5, 2'b00, 1'b0};
        tbl[3] = '{3'h2, 32'hCAFE_BABE, 4'hF, 0, 0, 2, 2'b10, 5, 2'b10, 1'b0};
        tbl[4] = '{3'h7, 32'h0000_00FF, 4'h1, 2, 2, 1, 2'b11, 6, 2'b11, 1'b0};
        tbl[5] = '{3'h3, 32'h5555_AAAA, 4'hC, 0, 0, 7, 2'b01, 10, 2'b01, 1'b0};
        tbl[6] = '{3'h5, 32'hDEAD_BEEF, 4'hF, 0, 0, -1, 2'b00, 10, 2'b11, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_awvalid", 64'(bus.awvalid), 64'(0));
        chk("rst_wvalid", 64'(bus.wvalid), 64'(0));
        chk("rst_bready", 64'(bus.bready), 64'(0));
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_rsp", 64'({rsp_valid, rsp_resp, rsp_timeout}), 64'(0));
        chk("rst_payload", 64'({bus.awaddr, bus.wdata, bus.wstrb}), 64'(0));
        chk("rst_awprot", 64'(bus.awprot), 64'(0));
        #2 rst_n = 1'b1;
        #1 chk("rel_cmd_ready", 64'(cmd_ready), 64'(1));

        for (int i = 0; i < 7; i++) do_txn(i, tbl[i]);

        // Stray B while idle: absorbed, no pulse, previous response held.
        @(posedge clk); #1;
        bus.bvalid = 1'b1;
        bus.bresp = 2'b00;
        @(negedge clk);
        chk("stray_bready", 64'(bus.bready), 64'(1));
        @(posedge clk); #1;
        bus.bvalid = 1'b0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("stray_no_rsp", 64'(n), 64'(0));
        chk("hold_resp", 64'(rsp_resp), 64'(2'b11));
        chk("hold_timeout", 64'(rsp_timeout), 64'(1));

        // Reset while AW/W are stalled in ISSUE.
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr = 3'h6;
        cmd_data = 32'h0BAD_F00D;
        cmd_strb = 4'hF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_awvalid", 64'({bus.awvalid, bus.wvalid}), 64'(2'b11));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valids", 64'({bus.awvalid, bus.wvalid}), 64'(0));
        chk("arst_ready", 64'({cmd_ready, bus.bready}), 64'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("arst_rel_ready", 64'(cmd_ready), 64'(1));
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || bus.awvalid || bus.wvalid) n++;
        end
        chk("arst_quiet", 64'(n), 64'(0));

        back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
